ps2_host_tx: RTL

- Host-to-device PS/2 transmitter. It is the send direction that pairs with the existing receive-only keyboard path.
- Lets the CPU send command bytes to a keyboard (LEDs 0xED, reset 0xFF, scan-set 0xF0) over the shared ps2_clk/ps2_data lines.
- Sits on the mmapper peripheral bus (a/d/we/spo style) in the clk_main domain.
- Drives the lines open-drain through output-enable signals; the top level ties each oe to a tri-state pulling low.

---
 rtl/ps2_host_tx_pkg.sv | 33 +++
 rtl/ps2_host_tx_sync.sv | 47 ++++
 rtl/ps2_host_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared definitions for the PS/2 host-to-device transmitter.
//   - register offsets on the a/d/we/spo peripheral bus
//   - status bit positions in the DATA/STATUS read word
//   - transmitter state encoding
//   - odd-parity helper used for the frame parity bit
package ps2_host_tx_pkg;

  // Register select values on input a
  localparam logic PS2TX_DATA = 1'b0;
  localparam logic PS2TX_CTRL = 1'b1;

  // Status bit positions in the DATA/STATUS read word (bits 7:0 hold txbyte)
  localparam int ST_BIT_BUSY    = 8;
  localparam int ST_BIT_DONE    = 9;
  localparam int ST_BIT_ACK_OK  = 10;
  localparam int ST_BIT_NOACK   = 11;
  localparam int ST_BIT_TIMEOUT = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_REQ      = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAITIDLE = 3'd5
  } tx_state_e;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// ps2_sync: two-flop synchronizers for the PS/2 clock and data pins plus a
// falling-edge detector on the synchronized clock. Usable by the receive path.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk_i           asynchronous PS/2 clock pin level
//   ps2_data_i          asynchronous PS/2 data pin level
//   sync_clk, sync_data synchronized pin levels
//   fall                one-cycle pulse on a synchronized clock falling edge
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic sync_clk,
  output logic sync_data,
  output logic fall
);

  logic clk_meta_r;
  logic clk_sync_r;
  logic clk_prev_r;
  logic data_meta_r;
  logic data_sync_r;

  // Synchronizer chains; reset to the idle-high bus level so no edge is
  // fabricated when reset is released
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_i;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data_i;
      data_sync_r <= data_meta_r;
    end
  end

  assign sync_clk  = clk_sync_r;
  assign sync_data = data_sync_r;
  assign fall      = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter on the a/d/we/spo bus.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   a                         register select (0 = DATA/STATUS, 1 = CTRL)
//   d, we                     write data and single-cycle write strobe
//   spo                       combinational read data
//   ps2_clk_i, ps2_data_i     asynchronous PS/2 pin levels
//   ps2_clk_oe, ps2_data_oe   1 = pull the line low (open drain)
//   irq                       level interrupt, follows the done status bit
// Frame: inhibit clock, request-to-send (data low), then the device clocks
// out 8 data bits LSB first, odd parity, stop, and answers with an ack bit.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLOCK_FREQ = 62500000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_MS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  output logic        irq
);

  localparam int INHIBIT_CYC = CLOCK_FREQ / 1000000 * INHIBIT_US;
  localparam int TIMEOUT_CYC = CLOCK_FREQ / 1000 * TIMEOUT_MS;
  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic sync_clk_s;
  logic sync_data_s;
  logic fall_s;

  tx_state_e        state_r,       state_next_s;
  logic [INH_W-1:0] inh_cnt_r,     inh_cnt_next_s;
  logic [TMO_W-1:0] tmo_cnt_r,     tmo_cnt_next_s;
  logic [3:0]       bitcnt_r,      bitcnt_next_s;
  logic [7:0]       txbyte_r,      txbyte_next_s;
  logic             done_r,        done_next_s;
  logic             ack_ok_r,      ack_ok_next_s;
  logic             err_noack_r,   err_noack_next_s;
  logic             err_timeout_r, err_timeout_next_s;
  logic             clk_oe_r,      clk_oe_next_s;
  logic             data_oe_r,     data_oe_next_s;

  logic wr_data_s;
  logic wr_ctrl_s;
  logic tmo_hit_s;
  logic busy_s;
  logic unused_d_s;

  ps2_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .sync_clk   (sync_clk_s),
    .sync_data  (sync_data_s),
    .fall       (fall_s)
  );

  assign wr_data_s  = we & (a == PS2TX_DATA);
  assign wr_ctrl_s  = we & (a == PS2TX_CTRL) & d[0];
  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
  assign busy_s     = (state_r != ST_IDLE);
  assign unused_d_s = ^d[31:8];

  // Next-state, next-output and status update logic. A CTRL clear is applied
  // first so that any completion in the same cycle overrides it.
  always_comb begin
    state_next_s       = state_r;
    inh_cnt_next_s     = inh_cnt_r;
    tmo_cnt_next_s     = tmo_cnt_r;
    bitcnt_next_s      = bitcnt_r;
    txbyte_next_s      = txbyte_r;
    done_next_s        = done_r;
    ack_ok_next_s      = ack_ok_r;
    err_noack_next_s   = err_noack_r;
    err_timeout_next_s = err_timeout_r;
    clk_oe_next_s      = clk_oe_r;
    data_oe_next_s     = data_oe_r;

    if (wr_ctrl_s) begin
      done_next_s        = 1'b0;
      ack_ok_next_s      = 1'b0;
      err_noack_next_s   = 1'b0;
      err_timeout_next_s = 1'b0;
    end else begin
      done_next_s        = done_r;
      ack_ok_next_s      = ack_ok_r;
      err_noack_next_s   = err_noack_r;
      err_timeout_next_s = err_timeout_r;
    end

    case (state_r)
      ST_IDLE: begin
        clk_oe_next_s  = 1'b0;
        data_oe_next_s = 1'b0;
        if (wr_data_s) begin
          txbyte_next_s      = d[7:0];
          done_next_s        = 1'b0;
          ack_ok_next_s      = 1'b0;
          err_noack_next_s   = 1'b0;
          err_timeout_next_s = 1'b0;
          inh_cnt_next_s     = {INH_W{1'b0}};
          clk_oe_next_s      = 1'b1;
          state_next_s       = ST_INHIBIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end

      // Hold the clock low; device edges are ignored here
      ST_INHIBIT: begin
        clk_oe_next_s  = 1'b1;
        data_oe_next_s = 1'b0;
        if (inh_cnt_r == INH_LAST) begin
          clk_oe_next_s  = 1'b0;
          data_oe_next_s = 1'b1;
          state_next_s   = ST_REQ;
        end else begin
          inh_cnt_next_s = inh_cnt_r + {{(INH_W-1){1'b0}}, 1'b1};
        end
      end

      // Start bit is already on the line; release clock and arm the counters
      ST_REQ: begin
        clk_oe_next_s  = 1'b0;
        data_oe_next_s = 1'b1;
        tmo_cnt_next_s = {TMO_W{1'b0}};
        bitcnt_next_s  = 4'd0;
        state_next_s   = ST_SEND;
      end

      // bitcnt_r holds the falls seen so far; the new fall is bitcnt_r + 1
      ST_SEND: begin
        if (fall_s) begin
          tmo_cnt_next_s = {TMO_W{1'b0}};
          bitcnt_next_s  = bitcnt_r + 4'd1;
          if (bitcnt_r < 4'd8) begin
            data_oe_next_s = ~txbyte_r[bitcnt_r[2:0]];
          end else if (bitcnt_r == 4'd8) begin
            data_oe_next_s = ~odd_parity(txbyte_r);
          end else begin
            data_oe_next_s = 1'b0;
            state_next_s   = ST_ACK;
          end
        end else if (tmo_hit_s) begin
          clk_oe_next_s      = 1'b0;
          data_oe_next_s     = 1'b0;
          err_timeout_next_s = 1'b1;
          done_next_s        = 1'b1;
          state_next_s       = ST_IDLE;
        end else begin
          tmo_cnt_next_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end

      // Device pulls data low during this clock pulse to acknowledge
      ST_ACK: begin
        if (fall_s) begin
          tmo_cnt_next_s = {TMO_W{1'b0}};
          if (sync_data_s == 1'b0) begin
            ack_ok_next_s = 1'b1;
          end else begin
            err_noack_next_s = 1'b1;
          end
          state_next_s = ST_WAITIDLE;
        end else if (tmo_hit_s) begin
          clk_oe_next_s      = 1'b0;
          data_oe_next_s     = 1'b0;
          err_timeout_next_s = 1'b1;
          done_next_s        = 1'b1;
          state_next_s       = ST_IDLE;
        end else begin
          tmo_cnt_next_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end

      // Finish once the device has released both lines
      ST_WAITIDLE: begin
        if (sync_clk_s && sync_data_s) begin
          done_next_s  = 1'b1;
          state_next_s = ST_IDLE;
        end else if (fall_s) begin
          tmo_cnt_next_s = {TMO_W{1'b0}};
        end else if (tmo_hit_s) begin
          clk_oe_next_s      = 1'b0;
          data_oe_next_s     = 1'b0;
          err_timeout_next_s = 1'b1;
          done_next_s        = 1'b1;
          state_next_s       = ST_IDLE;
        end else begin
          tmo_cnt_next_s = tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        clk_oe_next_s  = 1'b0;
        data_oe_next_s = 1'b0;
        state_next_s   = ST_IDLE;
      end
    endcase
  end

  // State, counter, status and line-driver registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      inh_cnt_r     <= {INH_W{1'b0}};
      tmo_cnt_r     <= {TMO_W{1'b0}};
      bitcnt_r      <= 4'd0;
      txbyte_r      <= 8'd0;
      done_r        <= 1'b0;
      ack_ok_r      <= 1'b0;
      err_noack_r   <= 1'b0;
      err_timeout_r <= 1'b0;
      clk_oe_r      <= 1'b0;
      data_oe_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      inh_cnt_r     <= inh_cnt_next_s;
      tmo_cnt_r     <= tmo_cnt_next_s;
      bitcnt_r      <= bitcnt_next_s;
      txbyte_r      <= txbyte_next_s;
      done_r        <= done_next_s;
      ack_ok_r      <= ack_ok_next_s;
      err_noack_r   <= err_noack_next_s;
      err_timeout_r <= err_timeout_next_s;
      clk_oe_r      <= clk_oe_next_s;
      data_oe_r     <= data_oe_next_s;
    end
  end

  // Read mux: DATA/STATUS word or zero for CTRL
  always_comb begin
    spo = 32'd0;
    if (a == PS2TX_DATA) begin
      spo[7:0]            = txbyte_r;
      spo[ST_BIT_BUSY]    = busy_s;
      spo[ST_BIT_DONE]    = done_r;
      spo[ST_BIT_ACK_OK]  = ack_ok_r;
      spo[ST_BIT_NOACK]   = err_noack_r;
      spo[ST_BIT_TIMEOUT] = err_timeout_r;
    end else begin
      spo = 32'd0;
    end
  end

  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign irq         = done_r;

endmodule
